// File: rtl/fetch_unit.sv
// Instruction-fetch front end for the pipelined RV32 core.
//
// Owns the fetch PC, issues in-order requests to a variable-latency
// instruction memory, buffers returned instructions with their PCs in a
// small FIFO and presents the FIFO head to decode. A redirect from execute
// clears the FIFO and discards every response still in flight.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched and
// perf_bubbles counters and ports.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_addr         word-aligned request address (fetch PC)
//   imem_rsp_valid    in-order response valid
//   imem_rdata        returned instruction
//   StallF            decode cannot accept; hold outputs
//   PCSrcE/PCTargetE  redirect request and target from execute
//   flushD            decode flush, asserted in the redirect cycle
//   validF            InstrF/PCF/PCPlus4F hold a real instruction
//   InstrF/PCF/PCPlus4F  FIFO head, all zero when !validF
//   perf_fetched      (FETCH_PERF_EN) saturating count of pops
//   perf_bubbles      (FETCH_PERF_EN) saturating count of !validF && !StallF
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal fetch; requests issued while credits remain
// DRAIN | after redirect; no requests, stale responses discarded

module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    output logic             flushD,
    output logic             validF,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [WIDTH-1:0] perf_fetched,
    output logic [WIDTH-1:0] perf_bubbles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] fetch_pc;
    logic [CW-1:0]    outstanding, outstanding_next;
    logic [CW-1:0]    drop, drop_next;
    logic [CW-1:0]    fifo_count;
    logic [CW:0]      credit_used;
    logic [AW-1:0]    fifo_wr, fifo_rd, pcq_wr, pcq_rd;
    logic [WIDTH-1:0] fifo_instr [DEPTH];
    logic [WIDTH-1:0] fifo_pc    [DEPTH];
    logic [WIDTH-1:0] pcq        [DEPTH];
    logic             issue, rsp_take, push, pop;

    // Credits cover both buffered entries and requests in flight, so a
    // response always has a FIFO slot waiting for it.
    assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign issue            = imem_req_valid && imem_req_ready;
    assign rsp_take         = imem_rsp_valid && (outstanding != '0);
    assign push             = rsp_take && (drop == '0) && !PCSrcE;
    assign pop              = validF && !StallF && !PCSrcE;
    assign outstanding_next = outstanding + CW'(issue) - CW'(rsp_take);

    // On redirect everything still in flight becomes stale; a response
    // consumed in the same cycle is already accounted for. No request is
    // issued in a redirect cycle, so issue does not enter this term.
    assign drop_next = PCSrcE ? (outstanding - CW'(rsp_take))
                              : (drop - CW'(rsp_take && (drop != '0)));

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        flushD         = PCSrcE;
        case (state)
            RUN: begin
                imem_req_valid = !rst && !PCSrcE && (credit_used < (CW+1)'(DEPTH));
                if (drop_next != '0) state_next = DRAIN;
            end
            DRAIN: begin
                if (drop_next == '0) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop        <= drop_next;
            if (PCSrcE) begin
                fetch_pc   <= PCTargetE & ~WIDTH'(3);
                fifo_count <= '0;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                pcq_wr     <= '0;
                pcq_rd     <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                    pcq_wr   <= pcq_wr + AW'(1);
                end
                if (push) begin
                    fifo_wr <= fifo_wr + AW'(1);
                    pcq_rd  <= pcq_rd + AW'(1);
                end
                if (pop) fifo_rd <= fifo_rd + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (issue) pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_instr[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]    <= pcq[pcq_rd];
        end
    end

    assign imem_addr = fetch_pc;
    assign validF    = (fifo_count != '0);
    assign InstrF    = validF ? fifo_instr[fifo_rd] : '0;
    assign PCF       = validF ? fifo_pc[fifo_rd] : '0;
    assign PCPlus4F  = validF ? (fifo_pc[fifo_rd] + WIDTH'(4)) : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + WIDTH'(1);
            if (!validF && !StallF && (perf_bubbles != '1))
                perf_bubbles <= perf_bubbles + WIDTH'(1);
        end
    end
`endif

endmodule
